lsu_ctrl: RTL and testbench

//  Load/store unit between the multi-cycle core and the unified byte-addressed memory (instr / data / peripheral regions).

---
 rtl/lsu_pkg.sv | 56 +++++
 rtl/lsu_load_fmt.sv | 35 +++
 rtl/lsu_ctrl.sv | 154 +++++++++++++++
 tb/tb_lsu_ctrl.sv | 360 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: funct3 codes, memory map, FSM states
// and the lane-placement helper used for store data.
package lsu_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    localparam int unsigned LSU_ADDR_W       = 12;
    localparam logic [11:0] LSU_INSTR_END    = 12'h200;
    localparam logic [11:0] LSU_DATA_END     = 12'h300;
    localparam logic [11:0] LSU_PERIPH_START = 12'h700;

    typedef enum logic [2:0] {
        StIdle,
        StRd,
        StRmwRd,
        StWr,
        StResp
    } lsu_state_e;

    function automatic logic [2:0] size_bytes(input logic [1:0] sz);
        logic [2:0] n;
        case (sz)
            2'b00:   n = 3'd1;
            2'b01:   n = 3'd2;
            default: n = 3'd4;
        endcase
        return n;
    endfunction

    // Memory lane j lives in byte ~j of the word (lane 0 is the MSB byte).
    function automatic logic [31:0] lane_merge(input logic [31:0] word,
                                               input logic [31:0] wdata,
                                               input logic [1:0]  lane,
                                               input logic [2:0]  nbytes);
        logic [3:0][7:0] r;
        logic [3:0][7:0] src;
        logic [1:0]      idx;
        r   = word;
        src = wdata;
        for (int i = 0; i < 4; i++) begin
            idx = lane + 2'(i);
            if (i < int'(nbytes)) begin
                r[~idx] = src[i];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/lsu_load_fmt.sv
// Load formatter: picks lanes starting at the access lane out of the big-endian memory
// word and returns them little-endian with sign or zero extension.
module lsu_load_fmt
    import lsu_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  lane,
    input  logic [2:0]  funct3,
    output logic [31:0] data
);

    logic [3:0][7:0] w;
    logic [3:0][7:0] b;
    logic [1:0]      idx;

    always_comb begin
        w    = word;
        b    = '0;
        idx  = '0;
        data = '0;
        for (int i = 0; i < 4; i++) begin
            idx  = lane + 2'(i);
            b[i] = w[~idx];
        end
        case (funct3)
            F3_LB:   data = {{24{b[0][7]}}, b[0]};
            F3_LBU:  data = {24'd0, b[0]};
            F3_LH:   data = {{16{b[1][7]}}, b[1], b[0]};
            F3_LHU:  data = {16'd0, b[1], b[0]};
            F3_LW:   data = {b[3], b[2], b[1], b[0]};
            default: data = '0;
        endcase
    end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store unit: turns byte/half/word core requests into aligned word accesses,
// with read-modify-write for sub-word data stores and fault reporting on the response.
module lsu_ctrl
    import lsu_pkg::*;
#(
    parameter int unsigned       ADDR_W       = LSU_ADDR_W,
    parameter logic [ADDR_W-1:0] INSTR_END    = LSU_INSTR_END,
    parameter logic [ADDR_W-1:0] DATA_END     = LSU_DATA_END,
    parameter logic [ADDR_W-1:0] PERIPH_START = LSU_PERIPH_START
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_funct3,
    input  logic [31:0]       req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err,
    output logic [ADDR_W-1:0] mem_a,
    output logic [31:0]       mem_wd,
    output logic              mem_we,
    input  logic [31:0]       mem_rd
);

    lsu_state_e        state_q, state_d;
    logic [ADDR_W-1:0] base_q;
    logic [1:0]        lane_q;
    logic [2:0]        funct3_q;
    logic [31:0]       wdata_q;
    logic [31:0]       wd_q;
    logic [31:0]       rdata_q;
    logic              err_q;

    logic [ADDR_W-1:0] req_lo;
    logic [1:0]        req_lane;
    logic              f3_bad;
    logic              misalign;
    logic              periph;
    logic              ro_store;
    logic              fault;
    logic [31:0]       load_data;

    always_comb begin
        req_lo   = req_addr[ADDR_W-1:0];
        req_lane = req_addr[1:0];
        if (req_we) begin
            f3_bad = req_funct3 > F3_SW;
        end else begin
            f3_bad = (req_funct3 == 3'b011) || (req_funct3[2:1] == 2'b11);
        end
        // An access may not straddle a word boundary.
        misalign = ((req_funct3[1:0] == 2'b01) && (req_lane == 2'b11)) ||
                   ((req_funct3[1:0] == 2'b10) && (req_lane != 2'b00));
        periph   = req_lo >= PERIPH_START;
        ro_store = req_we && ((req_lo < INSTR_END) || ((req_lo >= DATA_END) && !periph));
        fault    = (|req_addr[31:ADDR_W]) || f3_bad || misalign || ro_store;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle: begin
                if (req_valid) begin
                    if (fault) begin
                        state_d = StResp;
                    end else if (!req_we) begin
                        state_d = StRd;
                    end else if (periph || (req_funct3 == F3_SW)) begin
                        state_d = StWr;
                    end else begin
                        state_d = StRmwRd;
                    end
                end
            end
            StRd:    state_d = StResp;
            StRmwRd: state_d = StWr;
            StWr:    state_d = StResp;
            StResp:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    lsu_load_fmt u_load_fmt (
        .word   (mem_rd),
        .lane   (lane_q),
        .funct3 (funct3_q),
        .data   (load_data)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= StIdle;
            base_q   <= '0;
            lane_q   <= '0;
            funct3_q <= '0;
            wdata_q  <= '0;
            wd_q     <= '0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            case (state_q)
                StIdle: begin
                    if (req_valid) begin
                        base_q   <= {req_lo[ADDR_W-1:2], 2'b00};
                        lane_q   <= req_lane;
                        funct3_q <= req_funct3;
                        wdata_q  <= req_wdata;
                        // Direct stores (sw, peripheral) write lane-placed data over zeros.
                        wd_q     <= lane_merge('0, req_wdata, req_lane,
                                               size_bytes(req_funct3[1:0]));
                        if (fault) begin
                            rdata_q <= '0;
                            err_q   <= 1'b1;
                        end
                    end
                end
                StRd: begin
                    rdata_q <= load_data;
                    err_q   <= 1'b0;
                end
                StRmwRd: begin
                    wd_q <= lane_merge(mem_rd, wdata_q, lane_q, size_bytes(funct3_q[1:0]));
                end
                StWr: begin
                    rdata_q <= '0;
                    err_q   <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        req_ready = state_q == StIdle;
        rsp_valid = (state_q == StResp) && !reset;
        mem_we    = (state_q == StWr) && !reset;
        mem_a     = '0;
        mem_wd    = '0;
        if (state_q inside {StRd, StRmwRd, StWr}) begin
            mem_a = base_q;
        end
        if (state_q == StWr) begin
            mem_wd = wd_q;
        end
    end

    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Scoreboarded bench for lsu_ctrl: a byte-array reference model predicts responses and
// memory writes; independent monitors compare them as the DUT presents them.
module tb_lsu_ctrl;
    import lsu_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [11:0] mem_a;
    logic [31:0] mem_wd;
    logic        mem_we;
    logic [31:0] mem_rd;

    always #5 clk = ~clk;

    lsu_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err),
        .mem_a      (mem_a),
        .mem_wd     (mem_wd),
        .mem_we     (mem_we),
        .mem_rd     (mem_rd)
    );

    // Memory seen by the DUT, and the architectural byte view kept by the model.
    logic [7:0]  dmem    [4096];
    logic [7:0]  ref_mem [4096];
    int unsigned seed;
    logic        mem_init;
    logic        poke_en;
    logic [11:0] poke_a;
    logic [7:0]  poke_d;

    function automatic logic [7:0] init_byte(input int i);
        return 8'((i * 151 + int'(seed)) ^ (i >> 4));
    endfunction

    always_comb mem_rd = {dmem[mem_a], dmem[mem_a + 12'd1], dmem[mem_a + 12'd2],
                          dmem[mem_a + 12'd3]};

    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 4096; i++) dmem[i] <= init_byte(i);
        end else if (poke_en) begin
            dmem[poke_a] <= poke_d;
        end else if (mem_we) begin
            dmem[mem_a]          <= mem_wd[31:24];
            dmem[mem_a + 12'd1]  <= mem_wd[23:16];
            dmem[mem_a + 12'd2]  <= mem_wd[15:8];
            dmem[mem_a + 12'd3]  <= mem_wd[7:0];
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          cyc;
    } rsp_t;
    typedef struct {
        logic [11:0] a;
        logic [31:0] d;
        int          cyc;
    } wr_t;
    rsp_t rsp_q[$];
    wr_t  wr_q[$];

    int          nchecks = 0;
    int          nerr = 0;
    int          nwrites = 0;
    logic [31:0] last_rdata = '0;
    logic        last_err = 1'b0;
    logic [11:0] last_wa = '0;
    logic [31:0] last_wd = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchecks++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h, required %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        rsp_t e;
        #2;
        if (rsp_valid) begin
            last_rdata = rsp_rdata;
            last_err   = rsp_err;
            if (rsp_q.size() == 0) begin
                nchecks++;
                nerr++;
                $display("FAIL rsp_unexpected: got rsp_valid=1 rdata=%h, required no response",
                         rsp_rdata);
            end else begin
                e = rsp_q.pop_front();
                check("rsp_rdata", rsp_rdata, e.rdata);
                check("rsp_err", 32'(rsp_err), 32'(e.err));
                check("rsp_cycle", 32'(cyc), 32'(e.cyc));
            end
        end
    end

    always @(negedge clk) begin
        wr_t e;
        #2;
        if (mem_we) begin
            nwrites++;
            last_wa = mem_a;
            last_wd = mem_wd;
            if (wr_q.size() == 0) begin
                nchecks++;
                nerr++;
                $display("FAIL wr_unexpected: got mem_we=1 a=%h wd=%h, required no write",
                         mem_a, mem_wd);
            end else begin
                e = wr_q.pop_front();
                check("wr_addr", 32'(mem_a), 32'(e.a));
                check("wr_data", mem_wd, e.d);
                check("wr_cycle", 32'(cyc), 32'(e.cyc));
            end
        end
    end

    // Reference model: architectural little-endian bytes, stores commit at issue.
    task automatic model_push(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                              input logic [31:0] wd);
        rsp_t        r;
        wr_t         w;
        int unsigned sz, k, base;
        bit          legal, fault, periph;
        logic [31:0] v;
        int          lat;
        legal  = we ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        sz     = 1 << f3[1:0];
        k      = addr % 4;
        base   = addr - k;
        periph = (addr >= 32'h700) && (addr < 32'h1000);
        fault  = (addr >= 32'h1000) || !legal || (k + sz > 4) ||
                 (we && ((addr < 32'h200) || ((addr >= 32'h300) && (addr < 32'h700))));
        r.err   = fault;
        r.rdata = '0;
        if (fault) begin
            lat = 1;
        end else if (!we) begin
            lat = 2;
            v   = '0;
            for (int i = 0; i < int'(sz); i++)
                v = v | (32'(ref_mem[12'(addr + i)]) << (8 * i));
            if (!f3[2] && sz < 4 && v[8 * sz - 1]) v = v | (32'hFFFF_FFFF << (8 * sz));
            r.rdata = v;
        end else begin
            lat = (sz == 4 || periph) ? 2 : 3;
            if (periph) for (int j = 0; j < 4; j++) ref_mem[12'(base + j)] = 8'h00;
            for (int i = 0; i < int'(sz); i++) ref_mem[12'(addr + i)] = wd[8 * i +: 8];
            w.a   = 12'(base);
            w.d   = {ref_mem[12'(base)], ref_mem[12'(base + 1)], ref_mem[12'(base + 2)],
                     ref_mem[12'(base + 3)]};
            w.cyc = cyc + lat - 1;
            wr_q.push_back(w);
        end
        r.cyc = cyc + lat;
        rsp_q.push_back(r);
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            nchecks++;
            nerr++;
            $display("FAIL ready_timeout: got req_ready=0 for 20 cycles, required 1");
        end
    endtask

    // Called at a negedge; returns at the first negedge the unit is idle again.
    task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wd, input bit junk);
        int n = 0;
        wait_ready();
        model_push(we, f3, addr, wd);
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wd;
        @(negedge clk);
        while (!req_ready && n < 20) begin
            // Requests offered while busy must be ignored.
            req_valid  = junk;
            req_we     = 1'($urandom);
            req_funct3 = 3'($urandom);
            req_addr   = {20'd0, 12'($urandom)};
            req_wdata  = $urandom;
            @(negedge clk);
            n++;
        end
        req_valid = 1'b0;
    endtask

    task automatic poke(input logic [11:0] a, input logic [7:0] d);
        poke_en    = 1'b1;
        poke_a     = a;
        poke_d     = d;
        ref_mem[a] = d;
        @(negedge clk);
        poke_en = 1'b0;
    endtask

    int unsigned load_f3 [5];
    int unsigned store_f3[3];

    initial begin
        int          w0;
        int unsigned r;
        logic [31:0] a;
        logic        we;
        logic [2:0]  f3;

        load_f3  = '{0, 1, 2, 4, 5};
        store_f3 = '{0, 1, 2};
        seed = $urandom;
        for (int i = 0; i < 4096; i++) ref_mem[i] = init_byte(i);
        reset = 1'b1; mem_init = 1'b1; poke_en = 1'b0; poke_a = '0; poke_d = '0;
        req_valid = 1'b0; req_we = 1'b0; req_funct3 = '0; req_addr = '0; req_wdata = '0;
        @(negedge clk);
        mem_init = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check("reset_ready", 32'(req_ready), 32'd1);
        check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        check("reset_rdata", rsp_rdata, 32'd0);
        check("reset_err", 32'(rsp_err), 32'd0);
        check("reset_mem_a", 32'(mem_a), 32'd0);
        check("reset_mem_wd", mem_wd, 32'd0);
        check("reset_mem_we", 32'(mem_we), 32'd0);
        @(negedge clk);
        reset = 1'b0;

        poke(12'h204, 8'h11); poke(12'h205, 8'h22); poke(12'h206, 8'h33); poke(12'h207, 8'h44);
        w0 = nwrites;
        issue(1'b0, F3_LW, 32'h204, $urandom, 1'b0);
        check("t1_lw", last_rdata, 32'h4433_2211);
        check("t1_no_write", 32'(nwrites), 32'(w0));

        poke(12'h205, 8'h80);
        issue(1'b0, F3_LB, 32'h205, 32'h0, 1'b1);
        check("t2_lb", last_rdata, 32'hFFFF_FF80);
        issue(1'b0, F3_LBU, 32'h205, 32'h0, 1'b0);
        check("t2_lbu", last_rdata, 32'h0000_0080);
        issue(1'b0, F3_LH, 32'h204, 32'h0, 1'b1);
        check("t2_lh", last_rdata, 32'hFFFF_8011);

        poke(12'h205, 8'h22);
        issue(1'b1, F3_SB, 32'h206, 32'h0000_00AB, 1'b0);
        check("t3_sb_addr", 32'(last_wa), 32'h204);
        check("t3_sb_wd", last_wd, 32'h1122_AB44);

        w0 = nwrites;
        issue(1'b1, F3_SW, 32'h010, 32'h1234_5678, 1'b0);
        check("t4_sw_ro_err", 32'(last_err), 32'd1);
        issue(1'b0, F3_LW, 32'h202, 32'h0, 1'b1);
        check("t4_lw_mis_err", 32'(last_err), 32'd1);
        issue(1'b0, F3_LH, 32'h207, 32'h0, 1'b0);
        issue(1'b0, 3'b011, 32'h204, 32'h0, 1'b0);
        check("t4_no_write", 32'(nwrites), 32'(w0));

        issue(1'b1, F3_SH, 32'h702, 32'h0000_BEEF, 1'b0);
        check("t5_sh_addr", 32'(last_wa), 32'h700);
        check("t5_sh_wd", last_wd, 32'h0000_EFBE);

        // Reset in the middle of a read-modify-write.
        issue(1'b0, F3_LW, 32'h204, 32'h0, 1'b0);
        wait_ready();
        w0 = nwrites;
        req_valid = 1'b1; req_we = 1'b1; req_funct3 = F3_SB;
        req_addr = 32'h206; req_wdata = 32'h0000_00CD;
        @(negedge clk);
        req_valid = 1'b0;
        #1;
        check("t6_rmw_addr", 32'(mem_a), 32'h204);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("t6_ready", 32'(req_ready), 32'd1);
        check("t6_rsp_valid", 32'(rsp_valid), 32'd0);
        check("t6_rdata", rsp_rdata, 32'd0);
        check("t6_err", 32'(rsp_err), 32'd0);
        check("t6_mem_a", 32'(mem_a), 32'd0);
        check("t6_mem_wd", mem_wd, 32'd0);
        check("t6_mem_we", 32'(mem_we), 32'd0);

        // Reset while the write is being presented must suppress it.
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_funct3 = F3_SW;
        req_addr = 32'h208; req_wdata = 32'hDEAD_BEEF;
        @(negedge clk);
        req_valid = 1'b0;
        reset = 1'b1;
        #1;
        check("t7_we_gated", 32'(mem_we), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        check("t6_t7_no_write", 32'(nwrites), 32'(w0));
        issue(1'b0, F3_LW, 32'h204, 32'h0, 1'b0);
        issue(1'b0, F3_LW, 32'h208, 32'h0, 1'b0);

        for (int t = 0; t < 300; t++) begin
            r = $urandom_range(0, 9);
            case (r)
                0:       a = $urandom | 32'h0000_1000;
                1, 2:    a = $urandom_range(32'h000, 32'h1FF);
                3, 4, 5: a = $urandom_range(32'h200, 32'h2FF);
                6:       a = $urandom_range(32'h300, 32'h6FF);
                default: a = $urandom_range(32'h700, 32'hFFF);
            endcase
            we = 1'($urandom);
            if ($urandom_range(0, 3) != 0) begin
                f3 = we ? 3'(store_f3[$urandom_range(0, 2)]) : 3'(load_f3[$urandom_range(0, 4)]);
            end else begin
                f3 = 3'($urandom_range(0, 7));
            end
            if ($urandom_range(0, 1) == 1) begin
                if (f3[1:0] == 2'b01) a[0] = 1'b0;
                if (f3[1:0] == 2'b10) a[1:0] = 2'b00;
            end
            issue(we, f3, a, $urandom, 1'($urandom));
        end

        repeat (5) @(negedge clk);
        check("rsp_q_drained", 32'(rsp_q.size()), 32'd0);
        check("wr_q_drained", 32'(wr_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", nerr, nchecks);
        $finish;
    end

endmodule
